// File: rtl/dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bridge
// Brief    : Load/store bridge from the core memory port to a word-wide
//            valid/ready bus, with byte/half formatting and stall generation.
// Revision : 1.0
// ============================================================================
module dmem_bridge #(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  Funct3,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        MisalignErr,
   output logic        BusErr,
   output logic        bus_valid,
   input  logic        bus_ready,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata
);

   localparam int                c_CNT_W = $clog2(TIMEOUT) + 1;
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [c_CNT_W-1:0]   r_wait;
   logic [31:0]          r_rdata;
   logic                 r_misalign;
   logic                 r_buserr;
   logic                 r_we;
   logic [31:0]          r_addr;
   logic [3:0]           r_be;
   logic [31:0]          r_wdata;
   logic [1:0]           r_lane;
   logic [2:0]           r_f3;

   logic                 w_req;
   logic                 w_is_b;
   logic                 w_is_h;
   logic                 w_is_w;
   logic                 w_misalign;
   logic                 w_issue;
   logic                 w_handshake;
   logic                 w_timeout;
   logic [3:0]           w_be;
   logic [31:0]          w_wdata;
   logic [7:0]           w_byte;
   logic [15:0]          w_half;
   logic [31:0]          w_load;

   // Funct3[1:0] selects the size; 010/011/110/111 all fall through to word.
   assign w_req      = MemRead | MemWrite;
   assign w_is_b     = (Funct3[1:0] == 2'b00);
   assign w_is_h     = (Funct3[1:0] == 2'b01);
   assign w_is_w     = ~w_is_b & ~w_is_h;
   assign w_misalign = (w_is_h & Addr[0]) | (w_is_w & (Addr[1:0] != 2'b00));
   assign w_issue    = (r_state == S_IDLE) & w_req & ~w_misalign;

   assign w_handshake = (r_state == S_REQ) & bus_ready;
   assign w_timeout   = (r_state == S_REQ) & ~bus_ready & (r_wait == c_LAST);

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = WriteData;
      if (w_is_b) begin
         w_be    = 4'b0001 << Addr[1:0];
         w_wdata = {4{WriteData[7:0]}};
      end else if (w_is_h) begin
         w_be    = 4'b0011 << Addr[1:0];
         w_wdata = {2{WriteData[15:0]}};
      end
   end

   always_comb begin
      w_byte = 8'h00;
      case (r_lane)
         2'd0:    w_byte = bus_rdata[7:0];
         2'd1:    w_byte = bus_rdata[15:8];
         2'd2:    w_byte = bus_rdata[23:16];
         default: w_byte = bus_rdata[31:24];
      endcase
      w_half = r_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      w_load = bus_rdata;
      if (r_f3[1:0] == 2'b00)
         w_load = {{24{w_byte[7] & ~r_f3[2]}}, w_byte};
      else if (r_f3[1:0] == 2'b01)
         w_load = {{16{w_half[15] & ~r_f3[2]}}, w_half};
   end

   always_comb begin
      w_next    = r_state;
      Stall     = 1'b0;
      bus_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_issue) begin
               Stall  = 1'b1;
               w_next = S_REQ;
            end
         end
         S_REQ: begin
            Stall     = 1'b1;
            bus_valid = 1'b1;
            if (w_handshake || w_timeout)
               w_next = S_DONE;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wait     <= '0;
         r_rdata    <= '0;
         r_misalign <= 1'b0;
         r_buserr   <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_be       <= '0;
         r_wdata    <= '0;
         r_lane     <= '0;
         r_f3       <= '0;
      end else begin
         r_misalign <= (r_state == S_IDLE) & w_req & w_misalign;
         if (w_issue) begin
            r_wait  <= '0;
            r_we    <= MemWrite;
            r_addr  <= {Addr[31:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_lane  <= Addr[1:0];
            r_f3    <= Funct3;
         end
         if ((r_state == S_REQ) && !bus_ready)
            r_wait <= r_wait + c_CNT_W'(1);
         if (w_handshake && !r_we)
            r_rdata <= w_load;
         // A handshake on the final allowed cycle takes precedence over abort.
         if (w_timeout) begin
            r_buserr <= 1'b1;
            r_rdata  <= '0;
         end
      end
   end

   assign ReadData    = r_rdata;
   assign MisalignErr = r_misalign;
   assign BusErr      = r_buserr;
   assign bus_we      = r_we;
   assign bus_addr    = r_addr;
   assign bus_be      = r_be;
   assign bus_wdata   = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_bridge
// Brief    : Directed self-checking bench for dmem_bridge (TIMEOUT = 8).
// Revision : 1.0
// ============================================================================
module tb_dmem_bridge;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        MemRead = 1'b0;
   logic        MemWrite = 1'b0;
   logic [2:0]  Funct3 = 3'b010;
   logic [31:0] Addr = '0;
   logic [31:0] WriteData = '0;
   logic [31:0] ReadData;
   logic        Stall;
   logic        MisalignErr;
   logic        BusErr;
   logic        bus_valid;
   logic        bus_ready = 1'b0;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata = '0;

   int checks = 0;
   int failures = 0;

   dmem_bridge #(.TIMEOUT(8)) dut (
      .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
      .Funct3(Funct3), .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData),
      .Stall(Stall), .MisalignErr(MisalignErr), .BusErr(BusErr),
      .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic mr, input logic mw, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
      MemRead = mr; MemWrite = mw; Funct3 = f3; Addr = a; WriteData = wd;
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) tick();
      checks++; if (bus_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%h exp=0", bus_valid); end
      checks++; if (bus_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%h exp=0", bus_we); end
      checks++; if (bus_be !== 4'h0) begin failures++; $display("FAIL rst_be got=%h exp=0", bus_be); end
      checks++; if (bus_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", bus_addr); end
      checks++; if (bus_wdata !== 32'h0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", bus_wdata); end
      checks++; if (ReadData !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", ReadData); end
      checks++; if ({MisalignErr, BusErr, Stall} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {MisalignErr, BusErr, Stall}); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_load_word;
      bus_ready = 1'b1; bus_rdata = 32'hDEADBEEF;
      start(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
      checks++; if ({Stall, bus_valid} !== 2'b10) begin failures++; $display("FAIL lw_idle stall/valid got=%b exp=10", {Stall, bus_valid}); end
      tick();
      checks++; if ({Stall, bus_valid, bus_we} !== 3'b110) begin failures++; $display("FAIL lw_req stall/valid/we got=%b exp=110", {Stall, bus_valid, bus_we}); end
      checks++; if (bus_addr !== 32'h100) begin failures++; $display("FAIL lw_addr got=%h exp=00000100", bus_addr); end
      checks++; if (bus_be !== 4'b1111) begin failures++; $display("FAIL lw_be got=%b exp=1111", bus_be); end
      tick();
      checks++; if ({Stall, bus_valid} !== 2'b00) begin failures++; $display("FAIL lw_done stall/valid got=%b exp=00", {Stall, bus_valid}); end
      checks++; if (ReadData !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_rdata got=%h exp=deadbeef", ReadData); end
      MemRead = 1'b0;
      tick();
      checks++; if ({Stall, bus_valid} !== 2'b00) begin failures++; $display("FAIL lw_noreissue stall/valid got=%b exp=00", {Stall, bus_valid}); end
   endtask

   task automatic test_load_format;
      logic [2:0]  f3 [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001};
      logic [31:0] ad [6] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101, 32'h100};
      logic [31:0] rd [6] = '{32'h80FF0000, 32'h80FF0000, 32'h80011234, 32'h80011234, 32'h12345678, 32'h1234F678};
      logic [31:0] ex [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001, 32'h00000056, 32'hFFFFF678};
      for (int i = 0; i < 6; i++) begin
         bus_ready = 1'b1; bus_rdata = rd[i];
         start(1'b1, 1'b0, f3[i], ad[i], 32'h0);
         tick();
         tick();
         checks++; if (ReadData !== ex[i]) begin failures++; $display("FAIL load_fmt[%0d] got=%h exp=%h", i, ReadData, ex[i]); end
         checks++; if (MisalignErr !== 1'b0) begin failures++; $display("FAIL load_fmt_mis[%0d] got=%b exp=0", i, MisalignErr); end
         MemRead = 1'b0;
         tick();
      end
   endtask

   task automatic test_store;
      logic        mr [3] = '{1'b0, 1'b0, 1'b1};
      logic [2:0]  f3 [3] = '{3'b000, 3'b001, 3'b010};
      logic [31:0] ad [3] = '{32'h201, 32'h202, 32'h204};
      logic [3:0]  be [3] = '{4'b0010, 4'b1100, 4'b1111};
      logic [31:0] wd [3] = '{32'h78787878, 32'h56785678, 32'h12345678};
      logic [31:0] ba [3] = '{32'h200, 32'h200, 32'h204};
      for (int i = 0; i < 3; i++) begin
         bus_ready = 1'b1; bus_rdata = 32'hA5A5A5A5;
         start(mr[i], 1'b1, f3[i], ad[i], 32'h12345678);
         tick();
         checks++; if ({bus_valid, bus_we} !== 2'b11) begin failures++; $display("FAIL st_valid_we[%0d] got=%b exp=11", i, {bus_valid, bus_we}); end
         checks++; if (bus_be !== be[i]) begin failures++; $display("FAIL st_be[%0d] got=%b exp=%b", i, bus_be, be[i]); end
         checks++; if (bus_wdata !== wd[i]) begin failures++; $display("FAIL st_wdata[%0d] got=%h exp=%h", i, bus_wdata, wd[i]); end
         checks++; if (bus_addr !== ba[i]) begin failures++; $display("FAIL st_addr[%0d] got=%h exp=%h", i, bus_addr, ba[i]); end
         tick();
         checks++; if (ReadData !== 32'hFFFFF678) begin failures++; $display("FAIL st_rdata_hold[%0d] got=%h exp=fffff678", i, ReadData); end
         MemRead = 1'b0; MemWrite = 1'b0;
         tick();
      end
   endtask

   task automatic test_wait_states;
      bus_ready = 1'b0; bus_rdata = 32'h0BADF00D;
      start(1'b1, 1'b0, 3'b010, 32'h10C, 32'h0);
      checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL ws_idle_stall got=%b exp=1", Stall); end
      tick();
      for (int i = 0; i < 5; i++) begin
         checks++; if ({Stall, bus_valid, bus_we, bus_be} !== 7'b1101111) begin failures++; $display("FAIL ws_ctrl[%0d] got=%b exp=1101111", i, {Stall, bus_valid, bus_we, bus_be}); end
         checks++; if (bus_addr !== 32'h10C) begin failures++; $display("FAIL ws_addr[%0d] got=%h exp=0000010c", i, bus_addr); end
         tick();
      end
      bus_ready = 1'b1;
      #1;
      checks++; if ({Stall, bus_valid} !== 2'b11) begin failures++; $display("FAIL ws_hs stall/valid got=%b exp=11", {Stall, bus_valid}); end
      tick();
      checks++; if ({Stall, bus_valid} !== 2'b00) begin failures++; $display("FAIL ws_done stall/valid got=%b exp=00", {Stall, bus_valid}); end
      checks++; if (ReadData !== 32'h0BADF00D) begin failures++; $display("FAIL ws_rdata got=%h exp=0badf00d", ReadData); end
      MemRead = 1'b0;
      tick();
   endtask

   task automatic test_timeout_boundary;
      bus_ready = 1'b0; bus_rdata = 32'hCAFEF00D;
      start(1'b1, 1'b0, 3'b010, 32'h110, 32'h0);
      tick();
      repeat (7) tick();
      bus_ready = 1'b1;
      #1;
      checks++; if (bus_valid !== 1'b1) begin failures++; $display("FAIL tob_req8_valid got=%b exp=1", bus_valid); end
      tick();
      checks++; if (BusErr !== 1'b0) begin failures++; $display("FAIL tob_buserr got=%b exp=0", BusErr); end
      checks++; if (ReadData !== 32'hCAFEF00D) begin failures++; $display("FAIL tob_rdata got=%h exp=cafef00d", ReadData); end
      MemRead = 1'b0;
      tick();
   endtask

   task automatic test_timeout;
      int n;
      bus_ready = 1'b0; bus_rdata = 32'h55555555;
      start(1'b1, 1'b0, 3'b010, 32'h114, 32'h0);
      tick();
      n = 0;
      while (bus_valid === 1'b1 && n < 20) begin
         n++;
         tick();
      end
      checks++; if (n !== 8) begin failures++; $display("FAIL to_req_cycles got=%0d exp=8", n); end
      checks++; if ({BusErr, Stall} !== 2'b10) begin failures++; $display("FAIL to_done buserr/stall got=%b exp=10", {BusErr, Stall}); end
      checks++; if (ReadData !== 32'h0) begin failures++; $display("FAIL to_rdata got=%h exp=0", ReadData); end
      MemRead = 1'b0;
      tick();
      bus_ready = 1'b1; bus_rdata = 32'h11223344;
      start(1'b1, 1'b0, 3'b010, 32'h118, 32'h0);
      tick();
      tick();
      checks++; if (ReadData !== 32'h11223344) begin failures++; $display("FAIL to_next_rdata got=%h exp=11223344", ReadData); end
      checks++; if (BusErr !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b exp=1", BusErr); end
      MemRead = 1'b0;
      tick();
   endtask

   task automatic test_misalign;
      logic [2:0]  f3 [2] = '{3'b010, 3'b001};
      logic [31:0] ad [2] = '{32'h102, 32'h101};
      bus_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         start(1'b1, 1'b0, f3[i], ad[i], 32'h0);
         checks++; if ({Stall, MisalignErr} !== 2'b00) begin failures++; $display("FAIL mis_idle[%0d] stall/err got=%b exp=00", i, {Stall, MisalignErr}); end
         tick();
         checks++; if ({MisalignErr, bus_valid} !== 2'b10) begin failures++; $display("FAIL mis_pulse[%0d] err/valid got=%b exp=10", i, {MisalignErr, bus_valid}); end
         MemRead = 1'b0;
         tick();
         checks++; if ({MisalignErr, bus_valid} !== 2'b00) begin failures++; $display("FAIL mis_end[%0d] err/valid got=%b exp=00", i, {MisalignErr, bus_valid}); end
         checks++; if (ReadData !== 32'h11223344) begin failures++; $display("FAIL mis_rdata[%0d] got=%h exp=11223344", i, ReadData); end
      end
   endtask

   task automatic test_reset_mid_req;
      bus_ready = 1'b0;
      start(1'b1, 1'b0, 3'b010, 32'h120, 32'h0);
      tick();
      checks++; if (bus_valid !== 1'b1) begin failures++; $display("FAIL rmr_valid_before got=%b exp=1", bus_valid); end
      reset = 1'b1; MemRead = 1'b0;
      #1;
      checks++; if ({bus_valid, Stall, BusErr, MisalignErr} !== 4'b0000) begin failures++; $display("FAIL rmr_flags got=%b exp=0000", {bus_valid, Stall, BusErr, MisalignErr}); end
      checks++; if ({bus_addr, bus_be} !== 36'h0) begin failures++; $display("FAIL rmr_bus got=%h exp=0", {bus_addr, bus_be}); end
      checks++; if (ReadData !== 32'h0) begin failures++; $display("FAIL rmr_rdata got=%h exp=0", ReadData); end
      tick();
      reset = 1'b0;
      tick();
      checks++; if (bus_valid !== 1'b0) begin failures++; $display("FAIL rmr_idle_after got=%b exp=0", bus_valid); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_load_word();
      test_load_format();
      test_store();
      test_wait_states();
      test_timeout_boundary();
      test_timeout();
      test_misalign();
      test_reset_mid_req();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dmem_bridge.md
# dmem_bridge

Load/store bridge sitting directly downstream of the single-cycle datapath's memory port: it consumes the datapath's ALUResult (address) and WriteData, formats byte/half/word accesses onto a word-wide valid/ready memory bus, and returns the aligned, extended load value as ReadData to the writeback mux. While a bus transaction is in flight it asserts Stall so the core holds PC and suppresses the register write until the access completes.

## Interface
- TIMEOUT, 64: max consecutive REQ cycles without bus_ready before abort (≥2)
- clk  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- MemRead  in  1  current instruction is a load
- MemWrite  in  1  current instruction is a store (priority over MemRead)
- Funct3  in  3  Instr[14:12]: 000 B, 001 H, 010 W, 100 BU, 101 HU; others treated as W
- Addr  in  32  byte address (ALUResult)
- WriteData  in  32  store data (rs2)
- ReadData  out  32  formatted load result to writeback mux
- Stall  out  1  hold PC / block RegWrite this cycle
- MisalignErr  out  1  one-cycle pulse on misaligned access
- BusErr  out  1  sticky, set on timeout, cleared only by reset
- bus_valid  out  1  request valid
- bus_ready  in  1  memory accepts; for reads bus_rdata valid same cycle
- bus_we  out  1  1 = write
- bus_addr  out  32  word address, {Addr[31:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_rdata  in  32  read word

## Operation
- FSM: IDLE, REQ, DONE. Reset → IDLE.
- IDLE: req = MemRead|MemWrite. Misaligned = (H/HU & Addr[0]) | (W & Addr[1:0]≠0).
  - req & aligned: Stall=1 (combinational); latch bus_addr/we/be/wdata; → REQ.
  - req & misaligned: no bus access, Stall=0, MisalignErr=1 next cycle for one cycle, ReadData unchanged; stay IDLE.
- REQ: bus_valid=1, Stall=1; all bus outputs stable until handshake.
  - bus_valid & bus_ready: reads latch formatted data into ReadData register; → DONE.
  - no ready for TIMEOUT consecutive REQ cycles: → DONE, BusErr←1, ReadData←0. Handshake on the TIMEOUT-th cycle wins (no error).
- DONE: bus_valid=0, Stall=0; core retires instruction this cycle; → IDLE unconditionally (no reissue even though MemRead/MemWrite still high).
- Store formatting: B: be=4'b0001<<Addr[1:0], wdata={4{WD[7:0]}}; H: be=4'b0011<<Addr[1:0], wdata={2{WD[15:0]}}; W: be=4'b1111, wdata=WD.
- Load formatting (lane = Addr[1:0]): B sign-extends selected byte, BU zero-extends; H/HU select half Addr[1]; W full word.
- ReadData = registered value, held until next successful load or timeout.
- Reset values: state IDLE, bus_valid 0, bus_we 0, bus_be 0, bus_addr 0, bus_wdata 0, ReadData 0, MisalignErr 0, BusErr 0, wait counter 0. Reset mid-REQ drops bus_valid immediately (async).

## Timing
- Zero-wait memory: IDLE(stall) → REQ(handshake) → DONE(retire): 3 cycles per load/store; +1 per cycle bus_ready low.
- Stall high in IDLE-with-aligned-req and all REQ cycles; low in DONE.
- bus_valid never deasserts in REQ without handshake, except on timeout or reset.
- Wait counter clears on entering REQ; width clog2(TIMEOUT)+1.
- Non-memory instructions: Stall=0, no bus activity, 1 cycle.

## Test plan
- LW Addr=0x100, bus_ready tied 1, rdata=0xDEADBEEF → bus_addr=0x100, be=1111, we=0, Stall high 2 cycles, ReadData=0xDEADBEEF in DONE.
- LB Addr=0x103, rdata=0x80FF_0000 → ReadData=0xFFFFFF80; LBU same → 0x00000080; LH Addr=0x102 rdata=0x8001_xxxx → 0xFFFF8001.
- SB Addr=0x201 WD=0x12345678 → bus_be=0010, bus_wdata=0x78787878, bus_addr=0x200, we=1; SH Addr=0x202 → be=1100, wdata=0x56785678.
- bus_ready low 5 cycles then high → bus outputs stable throughout, Stall high 6 cycles in REQ +1 IDLE, retire in DONE.
- TIMEOUT=4, bus_ready never high → 4 REQ cycles, DONE with BusErr=1 (sticky), ReadData=0; next LW completes normally, BusErr remains 1.
- LW Addr=0x102 → no bus_valid, Stall=0, MisalignErr pulse 1 cycle; reset asserted mid-REQ → bus_valid=0 immediately, state IDLE, all outputs reset values.
